// File: rtl/reaction_test_ctrl_if.sv
// Bundle of the reaction game's control inputs and statistics outputs.
// The master side is whatever drives the buttons, tick and mode; the slave
// side is the controller itself.
`timescale 1ns/1ps
interface reaction_test_ctrl_if #(
  parameter int W     = 16,
  parameter int CNT_W = 8
);
  logic                 tick;
  logic                 start;
  logic                 react;
  logic                 rand_done;
  logic                 mode;
  logic                 finish_test;
  logic [2:0]           state;
  logic [W-1:0]         react_time;
  logic [W-1:0]         best_time;
  logic [W+CNT_W-1:0]   sum_time;
  logic [CNT_W-1:0]     round_cnt;
  logic [CNT_W-1:0]     fail_cnt;
  logic                 new_result;
  logic                 done;

  modport master (
    output tick, start, react, rand_done, mode, finish_test,
    input  state, react_time, best_time, sum_time, round_cnt, fail_cnt,
           new_result, done
  );

  modport slave (
    input  tick, start, react, rand_done, mode, finish_test,
    output state, react_time, best_time, sum_time, round_cnt, fail_cnt,
           new_result, done
  );
endinterface

// File: rtl/reaction_test_ctrl.sv
// Reaction-time game controller: single-shot or multi-round sessions with
// its own tick-driven reaction timer, too-fast / timeout fail detection and
// best / sum / round / fail statistics. All outputs come from registers.
`timescale 1ns/1ps
module reaction_test_ctrl #(
  parameter int W         = 16,
  parameter int CNT_W     = 8,
  parameter int MIN_TIME  = 256,
  parameter int TIMEOUT   = 4000,
  parameter int ROUNDS    = 5,
  parameter int MAX_FAILS = 1
) (
  input  logic              clk,
  input  logic              rst,
  reaction_test_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    ARMED   = 3'b001,
    FAIL    = 3'b010,
    GO      = 3'b011,
    RESULT  = 3'b111,
    SUMMARY = 3'b110
  } state_t;

  localparam logic [W-1:0]     LP_MIN    = W'(MIN_TIME);
  localparam logic [W-1:0]     LP_TMO    = W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_ROUNDS = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0] LP_MAXF   = CNT_W'(MAX_FAILS);

  state_t               r_state, w_next;
  logic [W-1:0]         r_timer;
  logic [W-1:0]         r_react_time;
  logic [W-1:0]         r_best;
  logic [W+CNT_W-1:0]   r_sum;
  logic [CNT_W-1:0]     r_round;
  logic [CNT_W-1:0]     r_fail;
  logic                 r_new_result;
  logic                 r_done;
  logic                 r_mode_q;

  // Transition qualifiers produced alongside the next state
  logic                 w_sess;   // new session begins
  logic                 w_go;     // random wait elapsed, timer restarts
  logic                 w_pass;   // valid reaction, entering RESULT
  logic                 w_fail;   // entering FAIL

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; react beats rand_done in ARMED and beats timeout in
  // GO, finish_test beats start in RESULT/FAIL
  always_comb begin
    w_next = r_state;
    w_sess = 1'b0;
    w_go   = 1'b0;
    w_pass = 1'b0;
    w_fail = 1'b0;
    case (r_state)
      IDLE, SUMMARY: begin
        if (bus.start) begin
          w_next = ARMED;
          w_sess = 1'b1;
        end
      end
      ARMED: begin
        if (bus.react) begin
          w_next = FAIL;
          w_fail = 1'b1;
        end else if (bus.rand_done) begin
          w_next = GO;
          w_go   = 1'b1;
        end
      end
      GO: begin
        if (bus.react) begin
          if (r_timer < LP_MIN) begin
            w_next = FAIL;
            w_fail = 1'b1;
          end else begin
            w_next = RESULT;
            w_pass = 1'b1;
          end
        end else if (r_timer == LP_TMO) begin
          w_next = FAIL;
          w_fail = 1'b1;
        end
      end
      RESULT: begin
        // round_cnt already includes this round's update here
        if (r_mode_q && (bus.finish_test || r_round == LP_ROUNDS))
          w_next = SUMMARY;
        else if (bus.start)
          w_next = ARMED;
      end
      FAIL: begin
        if (r_mode_q && (bus.finish_test || r_fail >= LP_MAXF))
          w_next = SUMMARY;
        else if (bus.start)
          w_next = ARMED;
      end
      default: w_next = IDLE;
    endcase
  end

  // Reaction timer: cleared when GO is entered, counts ticks, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_timer <= '0;
    else if (w_go)
      r_timer <= '0;
    else if (r_state == GO && bus.tick && r_timer < LP_TMO)
      r_timer <= r_timer + 1'b1;
  end

  // Session statistics, updated only on the cycle a state is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q     <= 1'b0;
      r_react_time <= '0;
      r_best       <= '1;
      r_sum        <= '0;
      r_round      <= '0;
      r_fail       <= '0;
    end else begin
      if (w_sess) begin
        r_mode_q <= bus.mode;
        r_best   <= '1;
        r_sum    <= '0;
        r_round  <= '0;
        r_fail   <= '0;
      end
      if (w_pass) begin
        // timer value before any same-cycle tick increment
        r_react_time <= r_timer;
        if (r_mode_q) begin
          r_round <= r_round + 1'b1;
          r_sum   <= r_sum + (W+CNT_W)'(r_timer);
          if (r_timer < r_best) r_best <= r_timer;
        end else begin
          r_best <= r_timer;
        end
      end
      if (w_fail && r_mode_q && r_fail != '1)
        r_fail <= r_fail + 1'b1;
    end
  end

  // Registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_new_result <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_new_result <= w_pass;
      r_done       <= (w_next == SUMMARY);
    end
  end

  assign bus.state      = r_state;
  assign bus.react_time = r_react_time;
  assign bus.best_time  = r_best;
  assign bus.sum_time   = r_sum;
  assign bus.round_cnt  = r_round;
  assign bus.fail_cnt   = r_fail;
  assign bus.new_result = r_new_result;
  assign bus.done       = r_done;

endmodule

// File: doc/reaction_test_ctrl.md
Name: reaction_test_ctrl

Overview:
- Parametrised next-generation controller for the LED reaction-time game.
- Runs single-shot (mode 0) or multi-round test sessions (mode 1).
- Owns its own reaction timer, driven by an external tick enable.
- Applies a too-fast threshold and a timeout, and accumulates best / sum / round / fail statistics for the display path.
- Sits between the button debouncers / random-delay generator and the LED/segment display decoder.

Parameters:
- W, 16, width of reaction time in ticks.
- CNT_W, 8, width of round and fail counters; sum width is W+CNT_W.
- MIN_TIME, 256, reaction below this tick count is "too fast" (fail).
- TIMEOUT, 4000, tick count at which a round without reaction fails.
- ROUNDS, 5, rounds per test session in mode 1 (1 .. 2^CNT_W-1).
- MAX_FAILS, 1, fails that end a mode-1 session (1 = first fail ends the test).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous reset, active-high.
- tick, input, 1, one-cycle timebase enable (e.g. 1 ms).
- start, input, 1, start/next-round pulse.
- react, input, 1, reaction button pulse.
- rand_done, input, 1, random delay elapsed pulse.
- mode, input, 1, 0 = single shot, 1 = multi-round test.
- finish_test, input, 1, user ends mode-1 session.
- state, output, 3, current state code.
- react_time, output, W, last valid reaction time.
- best_time, output, W, minimum valid time this session.
- sum_time, output, W+CNT_W, sum of valid times this session.
- round_cnt, output, CNT_W, valid rounds this session.
- fail_cnt, output, CNT_W, fails this session.
- new_result, output, 1, one-cycle pulse on entering RESULT.
- done, output, 1, high while in SUMMARY.

Behaviour:
- Reset (async, immediate): state = IDLE, react_time = 0, best_time = all ones, sum_time = 0, round_cnt = 0, fail_cnt = 0, new_result = 0, done = 0, internal timer = 0, mode_q = 0. Reset mid-round aborts with no stats update.
- State codes: IDLE = 000, ARMED = 001, FAIL = 010, GO = 011, RESULT = 111, SUMMARY = 110.
- Session start (start in IDLE or SUMMARY):
  - latch mode into mode_q;
  - clear best/sum/round/fail to reset values;
  - go to ARMED.
  - mode changes mid-session are ignored.
- ARMED (random wait; display shows dashes):
  - react -> FAIL (early press);
  - else rand_done -> GO, timer cleared to 0;
  - react and rand_done in the same cycle -> FAIL (react has priority).
- GO (waiting for reaction):
  - timer increments on each tick, saturating at TIMEOUT.
  - react with timer < MIN_TIME -> FAIL.
  - react with timer >= MIN_TIME -> RESULT, react_time <= timer. The value used is the pre-increment value even if tick is high that cycle.
  - No react and timer == TIMEOUT -> FAIL.
  - react wins over timeout in the same cycle.
- RESULT entry (the single cycle of the transition into RESULT):
  - new_result = 1 for exactly one cycle.
  - If mode_q = 1: round_cnt += 1; sum_time += react_time; best_time = min(best_time, react_time), where equal keeps the old value.
  - If mode_q = 0: best_time = react_time; stats counters are untouched.
- RESULT exits:
  - mode_q = 0: start -> ARMED.
  - mode_q = 1: finish_test, or round_cnt == ROUNDS (checked after update, so the earliest transition is the next cycle) -> SUMMARY; else start -> ARMED.
  - finish_test has priority over start.
- FAIL entry:
  - mode_q = 1: fail_cnt += 1.
  - If the updated fail_cnt >= MAX_FAILS, go to SUMMARY on the next cycle without waiting for start.
- FAIL exits:
  - mode_q = 1 and finish_test -> SUMMARY.
  - Otherwise start -> ARMED (retry); react_time is kept.
- SUMMARY:
  - done = 1; all stats held.
  - start -> new session (see above).
- IDLE ignores react, rand_done and finish_test.
- finish_test is ignored in mode 0 and in ARMED/GO.
- Counters never wrap: round_cnt is bounded by ROUNDS; fail_cnt saturates at 2^CNT_W-1. sum_time cannot overflow by width choice.
- All outputs are registered.
- Latencies: start -> ARMED is 1 cycle; react -> RESULT/FAIL is 1 cycle.

Test Plan (tick = 1 every cycle; W = 16, MIN_TIME = 100, TIMEOUT = 1000, ROUNDS = 3, MAX_FAILS = 2):
1. Mode 0: start, rand_done, react when timer = 150 -> state 111, react_time = 150, best_time = 150, new_result one cycle, round_cnt = 0.
2. Mode 1, three rounds with reactions at 300, 200, 250 -> after the third RESULT, state goes 110 the next cycle; best = 200, sum = 750, round_cnt = 3, done = 1.
3. Mode 1: react in ARMED, then start, then react at timer = 50 -> fail_cnt 1 then 2; SUMMARY one cycle after the second FAIL.
4. GO with no react -> FAIL when timer reaches 1000. Repeat with react in the cycle timer = 1000 -> RESULT, react_time = 1000.
5. react and rand_done in the same cycle in ARMED -> FAIL. In RESULT (mode 1, round 1), finish_test and start together -> SUMMARY.
6. Assert rst while in GO at timer = 500 -> state 000 immediately (async), all outputs at reset values; a subsequent start begins a clean session.
